// File: rtl/mux4x1_rr_collector.sv
// Four-lane round-robin collector: merges lane words into one registered
// output stream tagged with the source lane index.
module mux4x1_rr_collector #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    input  logic              out_ready,
    output logic [15:0]       xfer_cnt
);

    logic [1:0]        ptr;
    logic [3:0]        grant_oh;
    logic [1:0]        grant_idx;
    logic              can_accept;
    logic              take;
    logic              pop;
    logic [DATA_W-1:0] lane [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lane[g] = in_data[g*DATA_W +: DATA_W];
    end

    // Scan from ptr upward; first valid lane wins.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant_oh  = '0;
        grant_idx = ptr;
        found     = 1'b0;
        idx       = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                found         = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

    assign can_accept = !out_valid || out_ready;
    assign in_ready   = (rst || !can_accept) ? 4'b0000 : grant_oh;
    assign take       = |(in_valid & in_ready);
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
            xfer_cnt  <= 16'd0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= lane[grant_idx];
                out_sel   <= grant_idx;
                ptr       <= grant_idx + 2'd1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (pop) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux4x1_rr_collector.sv
// Directed bench for mux4x1_rr_collector: reset, single lane, round-robin,
// backpressure, pointer wrap/skip, counter wrap and mid-stream reset.
module tb_mux4x1_rr_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    mux4x1_rr_collector #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'h5000 + 16'(i);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_xfer_cnt: got %h want 0000", xfer_cnt);
        end
        checks++;
        if (out_data !== 16'h0000 || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_out_data: got %h/%0d want 0000/0",
                     out_data, out_sel);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready_held: got %b want 0000", in_ready);
        end
        rst = 1'b0;
        in_valid = 4'b0000;
        out_ready = 1'b0;
    endtask

    task automatic test_single_lane();
        do_reset();
        in_valid = 4'b0100;
        in_data[32 +: 16] = 16'h00A5;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_in_ready: got %b want 0100", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00A5 || out_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h s=%0d want v=1 d=00a5 s=2",
                     out_valid, out_data, out_sel);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_drain: got v=%b cnt=%0d want v=0 cnt=1",
                     out_valid, xfer_cnt);
        end
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL single_ptr3: got %b want 1000", in_ready);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'h1000 + 16'(i);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(i) ||
                out_data !== 16'h1000 + 16'(i % 4) || xfer_cnt !== 16'(i)) begin
                errors++;
                $display("FAIL rr_step%0d: got v=%b s=%0d d=%h cnt=%0d want v=1 s=%0d d=%h cnt=%0d",
                         i, out_valid, out_sel, out_data, xfer_cnt,
                         i % 4, 16'h1000 + 16'(i % 4), i);
            end
        end
        in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'd8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_total: got cnt=%0d v=%b want cnt=8 v=0",
                     xfer_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data[16 +: 16] = 16'hBEEF;
        in_valid = 4'b0010;
        out_ready = 1'b0;
        @(negedge clk);
        in_data[0 +: 16]  = 16'h2000;
        in_data[16 +: 16] = 16'h2001;
        in_data[32 +: 16] = 16'h2002;
        in_data[48 +: 16] = 16'h2003;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 ||
                out_data !== 16'hBEEF || out_sel !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: got r=%b v=%b d=%h s=%0d want r=0000 v=1 d=beef s=1",
                         i, in_ready, out_valid, out_data, out_sel);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0100", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 16'h2002 ||
            xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_release_out: got v=%b s=%0d d=%h cnt=%0d want v=1 s=2 d=2002 cnt=1",
                     out_valid, out_sel, out_data, xfer_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_skip();
        do_reset();
        in_data[32 +: 16] = 16'h3002;
        in_data[0 +: 16]  = 16'h3000;
        in_data[16 +: 16] = 16'h3001;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 4'b0011;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_ready0: got %b want 0001", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_sel !== 2'd0 || out_data !== 16'h3000) begin
            errors++;
            $display("FAIL wrap_out0: got s=%0d d=%h want s=0 d=3000",
                     out_sel, out_data);
        end
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ready1: got %b want 0010", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        checks++;
        if (out_sel !== 2'd1 || out_data !== 16'h3001) begin
            errors++;
            $display("FAIL wrap_out1: got s=%0d d=%h want s=1 d=3001",
                     out_sel, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_counter_wrap_reset();
        do_reset();
        in_data[48 +: 16] = 16'h7777;
        in_valid = 4'b1000;
        out_ready = 1'b1;
        repeat (65536) @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_max: got %h want ffff", xfer_cnt);
        end
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'h0000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL cnt_wrap: got cnt=%h v=%b want cnt=0000 v=1",
                     xfer_cnt, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 ||
            out_sel !== 2'd0 || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst_state: got v=%b d=%h s=%0d cnt=%0d want all 0",
                     out_valid, out_data, out_sel, xfer_cnt);
        end
        rst = 1'b0;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 4'b0000;
        in_data = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_counter_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
